cprv_mem_arbiter: RTL and testbench

Shares one unified memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage), one transaction in flight at a time. Data requests have priority, with a starvation guard so fetch always makes progress. Every request gets exactly one response, writes included, and that response is routed back to the requester that owns the transaction.

---
 rtl/cprv_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_cprv_mem_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cprv_mem_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction at a time.
// Data requests win ties; a streak counter lets fetch win after STARVE_LIMIT data grants in a row.
module cprv_mem_arbiter #(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_imem_i,
    output logic                  ready_imem_o,
    input  logic [DATA_WIDTH-1:0] instr_addr_imem_i,
    output logic                  valid_if_o,
    input  logic                  ready_if_i,
    output logic [DATA_WIDTH-1:0] instr_data_if_o,
    input  logic                  valid_dmem_i,
    output logic                  ready_dmem_o,
    input  logic [DATA_WIDTH-1:0] addr_dmem_i,
    input  logic [DATA_WIDTH-1:0] wdata_dmem_i,
    input  logic                  w_en_dmem_i,
    output logic                  valid_mem_dmem_o,
    input  logic                  ready_mem_dmem_i,
    output logic [DATA_WIDTH-1:0] rdata_dmem_o,
    output logic                  valid_mem_o,
    input  logic                  ready_mem_i,
    output logic [DATA_WIDTH-1:0] addr_mem_o,
    output logic [DATA_WIDTH-1:0] wdata_mem_o,
    output logic                  w_en_mem_o,
    input  logic                  valid_rsp_i,
    output logic                  ready_rsp_o,
    input  logic [DATA_WIDTH-1:0] rdata_rsp_i
);

    localparam int unsigned STREAK_W = 4;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

    state_e                state_q, state_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  w_en_q, w_en_d;
    logic                  owner_q, owner_d;

    logic grant_i_c, grant_d_c, valid_mem_c, ready_rsp_c, valid_if_c, valid_dm_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            streak_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            w_en_q   <= 1'b0;
            owner_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            w_en_q   <= w_en_d;
            owner_q  <= owner_d;
        end
    end

    // Grant selection, request capture and response routing; owner_q=1 means data owns the slot.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        w_en_d      = w_en_q;
        owner_d     = owner_q;
        grant_i_c   = 1'b0;
        grant_d_c   = 1'b0;
        valid_mem_c = 1'b0;
        ready_rsp_c = 1'b0;
        valid_if_c  = 1'b0;
        valid_dm_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_dmem_i && !(valid_imem_i && (streak_q == STREAK_MAX))) begin
                    grant_d_c = 1'b1;
                    addr_d    = addr_dmem_i;
                    wdata_d   = wdata_dmem_i;
                    w_en_d    = w_en_dmem_i;
                    owner_d   = 1'b1;
                    state_d   = S_REQ;
                    if (!valid_imem_i) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end else if (valid_imem_i) begin
                    grant_i_c = 1'b1;
                    addr_d    = instr_addr_imem_i;
                    wdata_d   = '0;
                    w_en_d    = 1'b0;
                    owner_d   = 1'b0;
                    streak_d  = '0;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                valid_mem_c = 1'b1;
                if (ready_mem_i) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                ready_rsp_c = owner_q ? ready_mem_dmem_i : ready_if_i;
                valid_if_c  = !owner_q && valid_rsp_i;
                valid_dm_c  = owner_q && valid_rsp_i;
                if (valid_rsp_i && ready_rsp_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are held low while reset is asserted.
    assign ready_imem_o     = rst_n && grant_i_c;
    assign ready_dmem_o     = rst_n && grant_d_c;
    assign valid_mem_o      = rst_n && valid_mem_c;
    assign ready_rsp_o      = rst_n && ready_rsp_c;
    assign valid_if_o       = rst_n && valid_if_c;
    assign valid_mem_dmem_o = rst_n && valid_dm_c;

    assign addr_mem_o      = addr_q;
    assign wdata_mem_o     = wdata_q;
    assign w_en_mem_o      = w_en_q;
    assign instr_data_if_o = rdata_rsp_i;
    assign rdata_dmem_o    = rdata_rsp_i;

endmodule

// File: tb/tb_cprv_mem_arbiter.sv
// Directed bench for cprv_mem_arbiter: inputs change 1 time unit after a rising edge,
// outputs are checked 2 time units after it.
module tb_cprv_mem_arbiter;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_imem_i, ready_imem_o;
    logic [W-1:0] instr_addr_imem_i;
    logic         valid_if_o, ready_if_i;
    logic [W-1:0] instr_data_if_o;
    logic         valid_dmem_i, ready_dmem_o;
    logic [W-1:0] addr_dmem_i, wdata_dmem_i;
    logic         w_en_dmem_i;
    logic         valid_mem_dmem_o, ready_mem_dmem_i;
    logic [W-1:0] rdata_dmem_o;
    logic         valid_mem_o, ready_mem_i;
    logic [W-1:0] addr_mem_o, wdata_mem_o;
    logic         w_en_mem_o;
    logic         valid_rsp_i, ready_rsp_o;
    logic [W-1:0] rdata_rsp_i;

    int total = 0;
    int bad   = 0;

    cprv_mem_arbiter #(.DATA_WIDTH(64), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_imem_i(valid_imem_i), .ready_imem_o(ready_imem_o),
        .instr_addr_imem_i(instr_addr_imem_i),
        .valid_if_o(valid_if_o), .ready_if_i(ready_if_i),
        .instr_data_if_o(instr_data_if_o),
        .valid_dmem_i(valid_dmem_i), .ready_dmem_o(ready_dmem_o),
        .addr_dmem_i(addr_dmem_i), .wdata_dmem_i(wdata_dmem_i), .w_en_dmem_i(w_en_dmem_i),
        .valid_mem_dmem_o(valid_mem_dmem_o), .ready_mem_dmem_i(ready_mem_dmem_i),
        .rdata_dmem_o(rdata_dmem_o),
        .valid_mem_o(valid_mem_o), .ready_mem_i(ready_mem_i),
        .addr_mem_o(addr_mem_o), .wdata_mem_o(wdata_mem_o), .w_en_mem_o(w_en_mem_o),
        .valid_rsp_i(valid_rsp_i), .ready_rsp_o(ready_rsp_o), .rdata_rsp_i(rdata_rsp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // One full transaction with zero-wait memory, entered in IDLE with requests already driven.
    task automatic run_txn(input string tag, input logic exp_data);
        chk({tag, "_rdy_d"}, 64'(ready_dmem_o), 64'(exp_data));
        chk({tag, "_rdy_i"}, 64'(ready_imem_o), 64'(!exp_data));
        tick(); ready_mem_i = 1'b1;
        tick(); ready_mem_i = 1'b0; valid_rsp_i = 1'b1; ready_if_i = 1'b1; ready_mem_dmem_i = 1'b1;
        tick(); valid_rsp_i = 1'b0;
        settle();
    endtask

    initial begin
        logic exp_seq [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        valid_imem_i = 1'b0; instr_addr_imem_i = '0; ready_if_i = 1'b0;
        valid_dmem_i = 1'b0; addr_dmem_i = '0; wdata_dmem_i = '0; w_en_dmem_i = 1'b0;
        ready_mem_dmem_i = 1'b0; ready_mem_i = 1'b0; valid_rsp_i = 1'b0; rdata_rsp_i = '0;

        // Reset state
        tick(); tick();
        valid_imem_i = 1'b1; valid_dmem_i = 1'b1; settle();
        chk("rst_force_rdy_i", 64'(ready_imem_o), 64'd0);
        chk("rst_force_rdy_d", 64'(ready_dmem_o), 64'd0);
        valid_imem_i = 1'b0; valid_dmem_i = 1'b0;
        tick(); rst_n = 1'b1; settle();
        chk("rst_valid_mem", 64'(valid_mem_o), 64'd0);
        chk("rst_addr", addr_mem_o, 64'd0);
        chk("rst_wdata", wdata_mem_o, 64'd0);
        chk("rst_wen", 64'(w_en_mem_o), 64'd0);

        // Single fetch
        valid_imem_i = 1'b1; instr_addr_imem_i = 64'h1000; settle();
        chk("f_grant", 64'(ready_imem_o), 64'd1);
        chk("f_no_dgrant", 64'(ready_dmem_o), 64'd0);
        tick(); valid_imem_i = 1'b0; ready_mem_i = 1'b1; settle();
        chk("f_valid_mem", 64'(valid_mem_o), 64'd1);
        chk("f_addr", addr_mem_o, 64'h1000);
        chk("f_wen", 64'(w_en_mem_o), 64'd0);
        chk("f_no_regrant", 64'(ready_imem_o), 64'd0);
        tick(); ready_mem_i = 1'b0; valid_rsp_i = 1'b1; rdata_rsp_i = 64'h13; ready_if_i = 1'b1; settle();
        chk("f_valid_if", 64'(valid_if_o), 64'd1);
        chk("f_data", instr_data_if_o, 64'h13);
        chk("f_no_dm_valid", 64'(valid_mem_dmem_o), 64'd0);
        chk("f_rsp_rdy", 64'(ready_rsp_o), 64'd1);
        chk("f_valid_mem_off", 64'(valid_mem_o), 64'd0);

        // Simultaneous fetch and store: data first, fetch at the next IDLE
        tick(); valid_rsp_i = 1'b0;
        valid_imem_i = 1'b1; instr_addr_imem_i = 64'h2000;
        valid_dmem_i = 1'b1; addr_dmem_i = 64'h80; wdata_dmem_i = 64'hDEAD; w_en_dmem_i = 1'b1;
        settle();
        chk("s_dgrant", 64'(ready_dmem_o), 64'd1);
        chk("s_no_igrant", 64'(ready_imem_o), 64'd0);
        tick(); valid_dmem_i = 1'b0; w_en_dmem_i = 1'b0; ready_mem_i = 1'b1; settle();
        chk("s_addr", addr_mem_o, 64'h80);
        chk("s_wdata", wdata_mem_o, 64'hDEAD);
        chk("s_wen", 64'(w_en_mem_o), 64'd1);
        tick(); ready_mem_i = 1'b0; valid_rsp_i = 1'b1; ready_mem_dmem_i = 1'b1; ready_if_i = 1'b0; settle();
        chk("s_dm_valid", 64'(valid_mem_dmem_o), 64'd1);
        chk("s_no_if_valid", 64'(valid_if_o), 64'd0);
        chk("s_rsp_rdy", 64'(ready_rsp_o), 64'd1);
        tick(); valid_rsp_i = 1'b0; settle();
        chk("s_igrant_next", 64'(ready_imem_o), 64'd1);
        tick(); valid_imem_i = 1'b0; ready_mem_i = 1'b1; settle();
        chk("s_faddr", addr_mem_o, 64'h2000);
        chk("s_fwen", 64'(w_en_mem_o), 64'd0);
        chk("s_fwdata", wdata_mem_o, 64'd0);
        tick(); ready_mem_i = 1'b0; valid_rsp_i = 1'b1; ready_if_i = 1'b1; settle();
        chk("s_f_valid_if", 64'(valid_if_o), 64'd1);
        tick(); valid_rsp_i = 1'b0;

        // Starvation guard: both requesters held valid
        valid_imem_i = 1'b1; instr_addr_imem_i = 64'h3000;
        valid_dmem_i = 1'b1; addr_dmem_i = 64'h90; w_en_dmem_i = 1'b0;
        settle();
        for (int k = 0; k < 10; k++) begin
            run_txn($sformatf("starve%0d", k), exp_seq[k]);
        end
        valid_imem_i = 1'b0; valid_dmem_i = 1'b0;

        // Backpressure on request and response sides
        valid_imem_i = 1'b1; instr_addr_imem_i = 64'h4000; ready_if_i = 1'b0; settle();
        chk("bp_grant", 64'(ready_imem_o), 64'd1);
        tick(); valid_imem_i = 1'b0; ready_mem_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("bp_stall_valid%0d", k), 64'(valid_mem_o), 64'd1);
            chk($sformatf("bp_stall_addr%0d", k), addr_mem_o, 64'h4000);
            tick();
        end
        ready_mem_i = 1'b1; settle();
        chk("bp_req_hs", 64'(valid_mem_o), 64'd1);
        tick(); ready_mem_i = 1'b0; valid_rsp_i = 1'b1; rdata_rsp_i = 64'h55;
        valid_imem_i = 1'b1; valid_dmem_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk($sformatf("bp_rsp_rdy%0d", k), 64'(ready_rsp_o), 64'd0);
            chk($sformatf("bp_valid_if%0d", k), 64'(valid_if_o), 64'd1);
            chk($sformatf("bp_no_grant%0d", k), 64'(ready_imem_o | ready_dmem_o), 64'd0);
            tick();
        end
        ready_if_i = 1'b1; settle();
        chk("bp_rsp_rdy_up", 64'(ready_rsp_o), 64'd1);
        chk("bp_rsp_data", instr_data_if_o, 64'h55);
        tick(); valid_rsp_i = 1'b0; valid_imem_i = 1'b0; valid_dmem_i = 1'b0; settle();
        chk("bp_idle_valid_if", 64'(valid_if_o), 64'd0);

        // Reset while in RESP with a response pending
        valid_dmem_i = 1'b1; addr_dmem_i = 64'h40; w_en_dmem_i = 1'b0; settle();
        chk("r_grant", 64'(ready_dmem_o), 64'd1);
        tick(); valid_dmem_i = 1'b0; ready_mem_i = 1'b1;
        tick(); ready_mem_i = 1'b0; valid_rsp_i = 1'b1; ready_mem_dmem_i = 1'b1; rst_n = 1'b0; settle();
        chk("r_rsp_rdy_forced", 64'(ready_rsp_o), 64'd0);
        chk("r_dm_valid_forced", 64'(valid_mem_dmem_o), 64'd0);
        tick(); rst_n = 1'b1; settle();
        chk("r_after_dm_valid", 64'(valid_mem_dmem_o), 64'd0);
        chk("r_after_rsp_rdy", 64'(ready_rsp_o), 64'd0);
        chk("r_after_valid_mem", 64'(valid_mem_o), 64'd0);
        chk("r_after_addr", addr_mem_o, 64'd0);
        valid_rsp_i = 1'b0; valid_dmem_i = 1'b1; valid_imem_i = 1'b1; addr_dmem_i = 64'h48; settle();
        run_txn("r_fresh0", 1'b1);
        run_txn("r_fresh1", 1'b1);
        run_txn("r_fresh2", 1'b1);
        run_txn("r_fresh3", 1'b1);
        run_txn("r_fresh4", 1'b0);
        valid_dmem_i = 1'b0; valid_imem_i = 1'b0;

        // Stray memory response in IDLE
        valid_rsp_i = 1'b1; ready_if_i = 1'b1; ready_mem_dmem_i = 1'b1; settle();
        chk("stray_rsp_rdy", 64'(ready_rsp_o), 64'd0);
        chk("stray_valid_if", 64'(valid_if_o), 64'd0);
        chk("stray_dm_valid", 64'(valid_mem_dmem_o), 64'd0);
        tick(); settle();
        chk("stray_still_rdy", 64'(ready_rsp_o), 64'd0);
        valid_rsp_i = 1'b0; valid_imem_i = 1'b1; instr_addr_imem_i = 64'h5000; settle();
        chk("stray_then_grant", 64'(ready_imem_o), 64'd1);
        tick(); valid_imem_i = 1'b0; settle();
        chk("stray_then_addr", addr_mem_o, 64'h5000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
